// File: rtl/bnn_stream_driver.sv
// ---------------------------------------------------------------------------
// bnn_stream_driver
//
// Host-side streaming driver for the BNN accelerator. One frame request pulls
// words from a host word source and hands them to the accelerator as a weight
// phase (acc_mode=1, W_WORDS words) followed by an image phase (acc_mode=0,
// D_WORDS words). It then waits for the accelerator result strobe, captures
// the 2-bit class and reports it, or flags a timeout after TIMEOUT cycles.
//
// Optional feature macro: BNN_DRV_WEIGHT_SKIP_EN
//   When defined, a frame started with reload_w=0 after a completed weight
//   phase skips straight to the image phase. When undefined, reload_w is
//   ignored and every frame loads weights then image.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   start, reload_w         frame request (IDLE only), weight reload select
//   host_data/valid/ready   host word source handshake
//   acc_mode/data/valid     word stream to the accelerator
//   acc_ready               accelerator accepts the current word
//   acc_out_en/out_data     accelerator result strobe and class
//   result, result_valid    captured class (held) and one-cycle capture pulse
//   timeout_err             one-cycle pulse when no result arrives in time
//   busy                    high whenever the driver is not IDLE
// ---------------------------------------------------------------------------
module bnn_stream_driver #(
   parameter int W_WORDS = 6,
   parameter int D_WORDS = 16,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        reload_w,
   input  logic [15:0] host_data,
   input  logic        host_valid,
   output logic        host_ready,
   output logic        acc_mode,
   output logic [15:0] acc_data,
   output logic        acc_valid,
   input  logic        acc_ready,
   input  logic        acc_out_en,
   input  logic [1:0]  acc_out_data,
   output logic [1:0]  result,
   output logic        result_valid,
   output logic        timeout_err,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_D, WAIT_RES} state_t;

   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] W_LEN   = CNT_W'(W_WORDS);
   localparam logic [CNT_W-1:0] D_LEN   = CNT_W'(D_WORDS);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_q;
   logic [CNT_W-1:0] fetchCnt_q;
   logic [CNT_W-1:0] sentCnt_q;
   logic [CNT_W-1:0] toCnt_q;
   logic             accValid_q;
   logic             accMode_q;
   logic [15:0]      accData_q;
   logic [1:0]       result_q;
   logic             resultValid_q;
   logic             timeoutErr_q;
   logic             busy_q;

`ifdef BNN_DRV_WEIGHT_SKIP_EN
   logic             weightsLoaded_q;
`else
   logic             unusedReload;
   assign unusedReload = reload_w;
`endif

   logic [CNT_W-1:0] phaseLen;
   logic             inLoad;
   logic             hostXfer;
   logic             accXfer;
   logic             phaseDone;

   // Phase length follows the current load state; the output register may
   // take a new word whenever it is empty or its word leaves this cycle.
   always_comb begin
      phaseLen   = (state_q == LOAD_W) ? W_LEN : D_LEN;
      inLoad     = (state_q == LOAD_W) || (state_q == LOAD_D);
      host_ready = inLoad && (fetchCnt_q < phaseLen) && (!accValid_q || acc_ready);
      hostXfer   = host_valid && host_ready;
      accXfer    = accValid_q && acc_ready;
      phaseDone  = inLoad && accXfer && ((sentCnt_q + ONE) == phaseLen);
   end

   // Single FSM block: output word register, fetch/sent/timeout counters and
   // the registered status outputs all advance together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         fetchCnt_q    <= '0;
         sentCnt_q     <= '0;
         toCnt_q       <= '0;
         accValid_q    <= 1'b0;
         accMode_q     <= 1'b0;
         accData_q     <= '0;
         result_q      <= '0;
         resultValid_q <= 1'b0;
         timeoutErr_q  <= 1'b0;
         busy_q        <= 1'b0;
`ifdef BNN_DRV_WEIGHT_SKIP_EN
         weightsLoaded_q <= 1'b0;
`endif
      end else begin
         resultValid_q <= 1'b0;
         timeoutErr_q  <= 1'b0;

         // A freshly fetched word replaces the old one, otherwise the
         // register empties once its word has been taken.
         if (hostXfer) begin
            accValid_q <= 1'b1;
            accData_q  <= host_data;
            accMode_q  <= (state_q == LOAD_W);
         end else if (accXfer) begin
            accValid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (start) begin
                  fetchCnt_q <= '0;
                  sentCnt_q  <= '0;
                  busy_q     <= 1'b1;
`ifdef BNN_DRV_WEIGHT_SKIP_EN
                  state_q    <= (weightsLoaded_q && !reload_w) ? LOAD_D : LOAD_W;
`else
                  state_q    <= LOAD_W;
`endif
               end
            end
            LOAD_W, LOAD_D: begin
               // The last word of a phase has been fetched before it is
               // sent, so no fetch can coincide with the phase change.
               if (phaseDone) begin
                  fetchCnt_q <= '0;
                  sentCnt_q  <= '0;
                  if (state_q == LOAD_W) begin
                     state_q <= LOAD_D;
`ifdef BNN_DRV_WEIGHT_SKIP_EN
                     weightsLoaded_q <= 1'b1;
`endif
                  end else begin
                     state_q <= WAIT_RES;
                     toCnt_q <= '0;
                  end
               end else begin
                  if (hostXfer) fetchCnt_q <= fetchCnt_q + ONE;
                  if (accXfer)  sentCnt_q  <= sentCnt_q + ONE;
               end
            end
            WAIT_RES: begin
               // A result arriving on the final timeout cycle still wins.
               if (acc_out_en) begin
                  result_q      <= acc_out_data;
                  resultValid_q <= 1'b1;
                  busy_q        <= 1'b0;
                  state_q       <= IDLE;
               end else if (toCnt_q == TO_LAST) begin
                  timeoutErr_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= IDLE;
               end else begin
                  toCnt_q <= toCnt_q + ONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign acc_valid    = accValid_q;
   assign acc_mode     = accMode_q;
   assign acc_data     = accData_q;
   assign result       = result_q;
   assign result_valid = resultValid_q;
   assign timeout_err  = timeoutErr_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_bnn_stream_driver.sv
// ---------------------------------------------------------------------------
// tb_bnn_stream_driver
//
// Self-checking bench for bnn_stream_driver with default parameters
// (W_WORDS=6, D_WORDS=16, TIMEOUT=1024). Words offered by the host are pushed
// to a scoreboard queue with the mode they must carry; words leaving on the
// accelerator side are popped and compared. Build with BNN_DRV_WEIGHT_SKIP_EN
// defined to exercise the weight skip feature.
// ---------------------------------------------------------------------------
module tb_bnn_stream_driver;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        reload_w;
   logic [15:0] host_data;
   logic        host_valid;
   logic        host_ready;
   logic        acc_mode;
   logic [15:0] acc_data;
   logic        acc_valid;
   logic        acc_ready;
   logic        acc_out_en;
   logic [1:0]  acc_out_data;
   logic [1:0]  result;
   logic        result_valid;
   logic        timeout_err;
   logic        busy;

   int          errors;
   int          checks;
   logic [16:0] expQ[$];
   logic [1:0]  expResult;

   bnn_stream_driver dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .reload_w     (reload_w),
      .host_data    (host_data),
      .host_valid   (host_valid),
      .host_ready   (host_ready),
      .acc_mode     (acc_mode),
      .acc_data     (acc_data),
      .acc_valid    (acc_valid),
      .acc_ready    (acc_ready),
      .acc_out_en   (acc_out_en),
      .acc_out_data (acc_out_data),
      .result       (result),
      .result_valid (result_valid),
      .timeout_err  (timeout_err),
      .busy         (busy)
   );

   // 10 time-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Last-resort guard so the run can never hang
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "[TB] watchdog");
   end

   // Pulse start for one cycle; returns 1 time unit after the accepting edge
   task automatic issueStart(input logic reload);
      start    = 1'b1;
      reload_w = reload;
      @(posedge clk); #1;
      start    = 1'b0;
      reload_w = 1'b0;
   endtask

   // Present one result strobe; returns 1 time unit after the capturing edge
   task automatic captureResult(input logic [1:0] cls);
      acc_out_en   = 1'b1;
      acc_out_data = cls;
      @(posedge clk); #1;
      acc_out_en   = 1'b0;
   endtask

   // Streams a frame of 'total' words starting at 'base'; the first nW are
   // expected as weights. Drives acc_ready low on cycles marked in stallMask
   // and pulses start on cycle startCyc. Returns tallies for the caller.
   task automatic applyStimulus(input int total, input int nW, input logic [15:0] base,
                                input logic [63:0] stallMask, input int startCyc,
                                output int sent, output int badWords, output int bubbles,
                                output int stallBad, output int busyLow);
      int          fetched;
      int          pendingBubble;
      logic [16:0] expWord;
      fetched       = 0;
      pendingBubble = 0;
      sent          = 0;
      badWords      = 0;
      bubbles       = 0;
      stallBad      = 0;
      busyLow       = 0;
      expQ.delete();
      for (int cyc = 0; cyc < 400 && sent < total; cyc++) begin
         host_valid = (fetched < total);
         host_data  = base + 16'(fetched);
         acc_ready  = (cyc < 64) ? !stallMask[cyc] : 1'b1;
         start      = (cyc == startCyc);
         @(negedge clk);
         if (!busy) busyLow++;
         if (acc_valid && !acc_ready) begin
            if (host_ready || expQ.size() == 0) stallBad++;
            else if (acc_data !== expQ[0][15:0]) stallBad++;
         end
         if (sent > 0 && !acc_valid) pendingBubble++;
         if (acc_valid && acc_ready) begin
            if (expQ.size() == 0) badWords++;
            else begin
               expWord = expQ.pop_front();
               if ({acc_mode, acc_data} !== expWord) begin
                  badWords++;
                  $display("[TB] word %0d: got mode=%0b data=%h want mode=%0b data=%h",
                           sent, acc_mode, acc_data, expWord[16], expWord[15:0]);
               end
            end
            sent++;
            bubbles += pendingBubble;
            pendingBubble = 0;
         end
         if (host_valid && host_ready) begin
            expQ.push_back({(fetched < nW) ? 1'b1 : 1'b0, host_data});
            fetched++;
         end
         @(posedge clk); #1;
      end
      host_valid = 1'b0;
      start      = 1'b0;
      acc_ready  = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({host_ready, acc_mode, acc_data, acc_valid, result, result_valid, timeout_err, busy} !== 24'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h want 000000",
                  {host_ready, acc_mode, acc_data, acc_valid, result, result_valid, timeout_err, busy});
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({host_ready, acc_valid, result, result_valid, timeout_err, busy} !== 7'h0) begin
         errors++;
         $display("[TB] FAIL idle_after_reset: got %h want 00",
                  {host_ready, acc_valid, result, result_valid, timeout_err, busy});
      end
      expResult = 2'b00;
   endtask

   task automatic test_stream();
      int sent, bad, bub, stl, bl;
      issueStart(1'b1);
      applyStimulus(22, 6, 16'h0001, 64'h0, -1, sent, bad, bub, stl, bl);
      checks++; if (sent !== 22) begin errors++; $display("[TB] FAIL stream_count: got %0d want 22", sent); end
      checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL stream_words: got %0d bad want 0", bad); end
      checks++; if (bub !== 1) begin errors++; $display("[TB] FAIL stream_bubbles: got %0d want 1", bub); end
      checks++; if (bl !== 0) begin errors++; $display("[TB] FAIL stream_busy: busy low %0d cycles want 0", bl); end
      checks++;
      if ({busy, acc_valid} !== 2'b10) begin
         errors++; $display("[TB] FAIL wait_res_entry: got busy,valid=%b want 10", {busy, acc_valid});
      end
      captureResult(2'b10);
      expResult = 2'b10;
      checks++;
      if ({result_valid, result, busy} !== {1'b1, expResult, 1'b0}) begin
         errors++; $display("[TB] FAIL capture: got rv,res,busy=%b want 1100", {result_valid, result, busy});
      end
      @(posedge clk); #1;
      checks++;
      if ({result_valid, result} !== {1'b0, expResult}) begin
         errors++; $display("[TB] FAIL capture_pulse: got rv,res=%b want 010", {result_valid, result});
      end
   endtask

   task automatic test_stall();
      int sent, bad, bub, stl, bl;
      issueStart(1'b1);
      applyStimulus(22, 6, 16'h0100, 64'h18, -1, sent, bad, bub, stl, bl);
      checks++; if (sent !== 22) begin errors++; $display("[TB] FAIL stall_count: got %0d want 22", sent); end
      checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL stall_words: got %0d bad want 0", bad); end
      checks++; if (stl !== 0) begin errors++; $display("[TB] FAIL stall_hold: got %0d bad stall cycles want 0", stl); end
      captureResult(2'b01);
      expResult = 2'b01;
      checks++;
      if ({result_valid, result} !== {1'b1, expResult}) begin
         errors++; $display("[TB] FAIL stall_capture: got rv,res=%b want 101", {result_valid, result});
      end
   endtask

   task automatic test_timeout();
      int sent, bad, bub, stl, bl;
      int waitCnt;
      issueStart(1'b1);
      applyStimulus(22, 6, 16'h0200, 64'h0, -1, sent, bad, bub, stl, bl);
      checks++; if (sent !== 22) begin errors++; $display("[TB] FAIL timeout_frame: got %0d want 22", sent); end
      waitCnt = 0;
      while (waitCnt < 1100 && !timeout_err) begin
         @(posedge clk); #1;
         waitCnt++;
      end
      checks++;
      if (waitCnt !== 1024) begin
         errors++; $display("[TB] FAIL timeout_latency: got %0d want 1024", waitCnt);
      end
      checks++;
      if ({result_valid, result, busy} !== {1'b0, expResult, 1'b0}) begin
         errors++; $display("[TB] FAIL timeout_state: got rv,res,busy=%b want 0%b0", {result_valid, result, busy}, expResult);
      end
      @(posedge clk); #1;
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++; $display("[TB] FAIL timeout_pulse: got %b want 0", timeout_err);
      end
      issueStart(1'b1);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL restart_busy: got %b want 1", busy); end
      applyStimulus(22, 6, 16'h0300, 64'h0, -1, sent, bad, bub, stl, bl);
      checks++;
      if ({sent, bad} !== {32'd22, 32'd0}) begin
         errors++; $display("[TB] FAIL restart_frame: got sent=%0d bad=%0d want 22/0", sent, bad);
      end
      captureResult(2'b00);
      expResult = 2'b00;
   endtask

   task automatic test_ignore();
      int sent, bad, bub, stl, bl;
      int busyHigh;
      issueStart(1'b1);
      applyStimulus(22, 6, 16'h0400, 64'h0, 12, sent, bad, bub, stl, bl);
      checks++; if (sent !== 22) begin errors++; $display("[TB] FAIL ignore_count: got %0d want 22", sent); end
      checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL ignore_words: got %0d bad want 0", bad); end
      captureResult(2'b11);
      expResult = 2'b11;
      checks++;
      if (result !== expResult) begin errors++; $display("[TB] FAIL ignore_capture: got %b want 11", result); end
      busyHigh = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (busy) busyHigh++;
      end
      checks++;
      if (busyHigh !== 0) begin errors++; $display("[TB] FAIL start_queued: busy %0d cycles want 0", busyHigh); end
      captureResult(2'b00);
      checks++;
      if ({result_valid, result} !== {1'b0, expResult}) begin
         errors++; $display("[TB] FAIL idle_strobe: got rv,res=%b want 011", {result_valid, result});
      end
   endtask

   task automatic test_reset_midframe();
      int sent, bad, bub, stl, bl;
      issueStart(1'b1);
      host_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         host_data = 16'h0500 + 16'(i);
         @(posedge clk); #1;
      end
      host_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      expResult = 2'b00;
      checks++;
      if ({acc_valid, busy, host_ready, result} !== 5'b0) begin
         errors++; $display("[TB] FAIL midframe_reset: got valid,busy,rdy,res=%b want 00000", {acc_valid, busy, host_ready, result});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issueStart(1'b0);
      applyStimulus(22, 6, 16'h0600, 64'h0, -1, sent, bad, bub, stl, bl);
      checks++;
      if ({sent, bad, bub} !== {32'd22, 32'd0, 32'd1}) begin
         errors++; $display("[TB] FAIL post_reset_frame: got sent=%0d bad=%0d bub=%0d want 22/0/1", sent, bad, bub);
      end
      captureResult(2'b10);
      expResult = 2'b10;
   endtask

   task automatic test_weight_skip();
      int sent, bad, bub, stl, bl;
`ifdef BNN_DRV_WEIGHT_SKIP_EN
      issueStart(1'b0);
      applyStimulus(16, 0, 16'h0700, 64'h0, -1, sent, bad, bub, stl, bl);
      checks++;
      if ({sent, bad, bub} !== {32'd16, 32'd0, 32'd0}) begin
         errors++; $display("[TB] FAIL skip_frame: got sent=%0d bad=%0d bub=%0d want 16/0/0", sent, bad, bub);
      end
      captureResult(2'b01);
      checks++;
      if (result !== 2'b01) begin errors++; $display("[TB] FAIL skip_capture: got %b want 01", result); end
      issueStart(1'b1);
      applyStimulus(22, 6, 16'h0800, 64'h0, -1, sent, bad, bub, stl, bl);
      checks++;
      if ({sent, bad, bub} !== {32'd22, 32'd0, 32'd1}) begin
         errors++; $display("[TB] FAIL reload_frame: got sent=%0d bad=%0d bub=%0d want 22/0/1", sent, bad, bub);
      end
      captureResult(2'b11);
      checks++;
      if (result !== 2'b11) begin errors++; $display("[TB] FAIL reload_capture: got %b want 11", result); end
`else
      issueStart(1'b0);
      applyStimulus(22, 6, 16'h0700, 64'h0, -1, sent, bad, bub, stl, bl);
      checks++;
      if ({sent, bad, bub} !== {32'd22, 32'd0, 32'd1}) begin
         errors++; $display("[TB] FAIL noskip_frame: got sent=%0d bad=%0d bub=%0d want 22/0/1", sent, bad, bub);
      end
      captureResult(2'b01);
      checks++;
      if (result !== 2'b01) begin errors++; $display("[TB] FAIL noskip_capture: got %b want 01", result); end
`endif
   endtask

   initial begin
      errors       = 0;
      checks       = 0;
      start        = 1'b0;
      reload_w     = 1'b0;
      host_data    = '0;
      host_valid   = 1'b0;
      acc_ready    = 1'b1;
      acc_out_en   = 1'b0;
      acc_out_data = 2'b00;
      expResult    = 2'b00;
      test_reset();
      test_stream();
      test_stall();
      test_timeout();
      test_ignore();
      test_reset_midframe();
      test_weight_skip();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
